crossing_controller: RTL
========================

Name: crossing_controller

Overview:
Timed sequencer for the 3-bit traffic-light datapath on the board. It steps lights through RED -> RED_AMBER -> GREEN -> AMBER -> RED using per-phase dwell counters. A pedestrian push-button request ends GREEN once a minimum green time has elapsed. It drives the lights word, a walk indicator and a request-pending (wait) indicator.

Parameters:
CNT_W, 8, width of the phase dwell counter.
RED_CYC, 8, enabled cycles spent in RED (walk phase); 1..2^CNT_W.
RA_CYC, 2, enabled cycles spent in RED_AMBER; 1..2^CNT_W.
GREEN_MIN, 6, minimum enabled cycles in GREEN before a request is served; 1..2^CNT_W.
AMBER_CYC, 2, enabled cycles spent in AMBER; 1..2^CNT_W.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  phase-advance enable; when 0, state and counter hold.
button  input  1  pedestrian request, synchronous level, sampled every clk.
lights  output  3  {red, amber, green}.
walk  output  1  pedestrian walk lamp.
wait_led  output  1  request latched, not yet served.

Behaviour:
- One clock, clk. rst is asynchronous, active-high. While rst=1: state=RED, cnt=0, lights=3'b100, walk=0, wait_led=0.
- Lights encoding by state: RED=100, RED_AMBER=110, GREEN=001, AMBER=010. lights is a registered state decode, with no combinational path from button or en.
- cnt increments on each clk edge where en=1. It clears to 0 on every state transition. With en=0, cnt and state hold.
- RED -> RED_AMBER: when en=1 and cnt==RED_CYC-1.
- RED_AMBER -> GREEN: when en=1 and cnt==RA_CYC-1.
- GREEN -> AMBER: when en=1, req=1 and cnt>=GREEN_MIN-1.
  - cnt saturates at GREEN_MIN-1 while in GREEN.
  - With no request, GREEN holds indefinitely.
- AMBER -> RED: when en=1 and cnt==AMBER_CYC-1.
- Request latch req (drives wait_led):
  - Set on the edge after any cycle with button=1 while state is RED_AMBER, GREEN or AMBER. Setting is independent of en.
  - Cleared on the AMBER -> RED transition edge. Clear wins over a simultaneous button.
  - button while in RED is ignored, because the walk is already in progress.
- walk:
  - Set on the AMBER -> RED transition edge; cleared on the RED -> RED_AMBER edge.
  - The RED state entered from reset has walk=0. This gives an all-red safe start, not a serviced walk.
- Latency:
  - Request in GREEN with min time elapsed: lights=010 on the 2nd edge after the button cycle (1 edge to latch req, 1 edge to transition).
  - wait_led=1 one cycle after button.
- Reset mid-phase: immediate return to RED/100, with walk, wait_led and cnt cleared. The latched request is lost.

Test Plan:
1. Reset, then release rst with en=1, button=0:
   - lights=100, walk=0 for 8 cycles.
   - Then 110 for 2 cycles.
   - Then 001, held for 50+ cycles; wait_led=0 throughout.
2. Early request: 1-cycle button pulse in GREEN cycle 1:
   - wait_led=1 from next cycle.
   - GREEN lasts exactly 6 cycles, then 010 for 2 cycles.
   - Then 100 with walk=1, wait_led=0 for 8 cycles.
   - Then 110 with walk=0.
3. Late request: button pulse after 20 GREEN cycles -> lights=010 two edges after the button cycle.
4. Button during RED (walk=1) -> wait_led stays 0, and GREEN following that RED holds indefinitely. Button during the AMBER cycle that transitions to RED -> also not latched.
5. en=0 for 5 cycles mid-RED (cnt=3):
   - lights and walk frozen.
   - After en returns, RED lasts 5 more enabled cycles.
   - A button during en=0 in GREEN still sets wait_led.
6. Assert rst asynchronously mid-GREEN with req pending -> lights=100, walk=0 and wait_led=0 before the next clk edge. Restart follows scenario 1 timing.

Source files
------------

// File: rtl/crossing_controller.sv
// Timed traffic-light sequencer with a pedestrian request latch.
// Cycle: RED -> RED_AMBER -> GREEN -> AMBER -> RED. Each phase ends after its
// dwell count, except GREEN, which ends only on a latched request once the
// minimum green time has elapsed. Every output is driven from a register.
module crossing_controller #(
  parameter int CNT_W     = 8,
  parameter int RED_CYC   = 8,
  parameter int RA_CYC    = 2,
  parameter int GREEN_MIN = 6,
  parameter int AMBER_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       button,
  output logic [2:0] lights,
  output logic       walk,
  output logic       wait_led
);

  typedef enum logic [1:0] {
    ST_RED       = 2'd0,
    ST_RED_AMBER = 2'd1,
    ST_GREEN     = 2'd2,
    ST_AMBER     = 2'd3
  } state_t;

  // Final count value of each phase. The counter is CNT_W bits wide, so a
  // dwell of 2^CNT_W cycles still has its last value inside the counter range.
  localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(RED_CYC - 1);
  localparam logic [CNT_W-1:0] RA_LAST    = CNT_W'(RA_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] AMBER_LAST = CNT_W'(AMBER_CYC - 1);

  // Lamp word {red, amber, green} for each state.
  function automatic logic [2:0] lights_of(input state_t st);
    logic [2:0] word;
    case (st)
      ST_RED:       word = 3'b100;
      ST_RED_AMBER: word = 3'b110;
      ST_GREEN:     word = 3'b001;
      ST_AMBER:     word = 3'b010;
      default:      word = 3'b100;
    endcase
    return word;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             walk_q, walk_d;
  logic [2:0]       lights_q, lights_d;
  logic             last_s;
  state_t           next_st_s;
  logic             adv_s;

  // Decide whether the current phase is finished, and name its successor.
  always_comb begin
    last_s    = 1'b0;
    next_st_s = ST_RED;
    case (state_q)
      ST_RED: begin
        last_s    = (cnt_q == RED_LAST);
        next_st_s = ST_RED_AMBER;
      end
      ST_RED_AMBER: begin
        last_s    = (cnt_q == RA_LAST);
        next_st_s = ST_GREEN;
      end
      ST_GREEN: begin
        last_s    = req_q && (cnt_q >= GREEN_LAST);
        next_st_s = ST_AMBER;
      end
      ST_AMBER: begin
        last_s    = (cnt_q == AMBER_LAST);
        next_st_s = ST_RED;
      end
      default: begin
        last_s    = 1'b1;
        next_st_s = ST_RED;
      end
    endcase
  end

  // Next-state values for the phase, the counter, the request latch and the lamps.
  always_comb begin
    adv_s   = en && last_s;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (adv_s) begin
      state_d = next_st_s;
      cnt_d   = '0;
    end else if (en) begin
      // GREEN parks its counter at the minimum so an arbitrarily long wait
      // for a request never wraps the counter.
      if (state_q == ST_GREEN && cnt_q >= GREEN_LAST) begin
        cnt_d = GREEN_LAST;
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end

    // Entering RED serves the request, and the clear overrides a button
    // press in that same cycle. A press during RED is ignored because the
    // walk is already in progress.
    if (adv_s && state_q == ST_AMBER) begin
      req_d = 1'b0;
    end else if (button && state_q != ST_RED) begin
      req_d = 1'b1;
    end else begin
      req_d = req_q;
    end

    // Walk lamp is lit only for a RED entered from AMBER, so the all-red
    // RED that follows reset shows walk=0.
    if (adv_s && state_q == ST_AMBER) begin
      walk_d = 1'b1;
    end else if (adv_s && state_q == ST_RED) begin
      walk_d = 1'b0;
    end else begin
      walk_d = walk_q;
    end

    lights_d = lights_of(state_d);
  end

  // Sequencer state and registered outputs; reset forces the all-red safe state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RED;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      walk_q   <= 1'b0;
      lights_q <= 3'b100;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      walk_q   <= walk_d;
      lights_q <= lights_d;
    end
  end

  assign lights   = lights_q;
  assign walk     = walk_q;
  assign wait_led = req_q;

endmodule
